// File: rtl/dht11_responder.sv
// -----------------------------------------------------------------------------
// dht11_responder
//
// Emulates the sensor end of the single-wire DHT11 protocol. The block waits
// for a host start pulse on the open-drain line. When the pulse is long enough,
// it drives the response preamble, then a 40-bit frame, then an end pulse.
//
// Frame layout, sent MSB first (bit 39 first):
//   {rh_int, rh_dec, temp_int, temp_dec, chk}
//
// All timing is expressed in ticks. One tick is TICK_DIV clk cycles, which is
// 10 us at 100 MHz.
//
// Ports
//   clk          system clock
//   reset        asynchronous reset, active low
//   enable       when low, new start pulses are ignored; a frame already in
//                progress still completes
//   rh_int       humidity integer byte
//   rh_dec       humidity decimal byte
//   temp_int     temperature integer byte
//   temp_dec     temperature decimal byte
//   corrupt_chk  when high at start acceptance, the transmitted checksum has
//                its LSB flipped
//   busy         high from start acceptance until the end pulse completes
//   frame_done   one-clk pulse when the end pulse completes
//   dht11_io     open-drain line: driven 0 or Z, never 1 (external pull-up)
//
// Line handshake: the line is shared, so there is no valid/ready pair. A
// party only ever pulls the line low or releases it. This block releases the
// line whenever it is not in one of its own low phases. It ignores the line
// entirely while it is transmitting.
//
// Debug: the FSM state is held in state_q, a named register of type state_t,
// so checkers can bind to it directly.
// -----------------------------------------------------------------------------
module dht11_responder #(
  parameter int TICK_DIV         = 1000,
  parameter int MIN_START_TICKS  = 1800,
  parameter int RESP_DELAY_TICKS = 4,
  parameter int RESP_TICKS       = 8,
  parameter int BIT_LOW_TICKS    = 5,
  parameter int ZERO_HIGH_TICKS  = 3,
  parameter int ONE_HIGH_TICKS   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] rh_int,
  input  logic [7:0] rh_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       corrupt_chk,
  output logic       busy,
  output logic       frame_done,
  inout  wire        dht11_io
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------

  // Width of the tick prescaler.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // The phase counter must hold the largest tick count used by any phase.
  localparam int MAX_A = (MIN_START_TICKS > RESP_DELAY_TICKS) ? MIN_START_TICKS
                                                              : RESP_DELAY_TICKS;
  localparam int MAX_B = (RESP_TICKS > BIT_LOW_TICKS) ? RESP_TICKS : BIT_LOW_TICKS;
  localparam int MAX_C = (ZERO_HIGH_TICKS > ONE_HIGH_TICKS) ? ZERO_HIGH_TICKS
                                                            : ONE_HIGH_TICKS;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_T  = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW     = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // A timed phase of N ticks ends on the tick where cnt_q == N-1.
  localparam logic [CW-1:0] MIN_START  = CW'(MIN_START_TICKS);
  localparam logic [CW-1:0] DELAY_LAST = CW'(RESP_DELAY_TICKS - 1);
  localparam logic [CW-1:0] RESP_LAST  = CW'(RESP_TICKS - 1);
  localparam logic [CW-1:0] BITL_LAST  = CW'(BIT_LOW_TICKS - 1);
  localparam logic [CW-1:0] ZERO_LAST  = CW'(ZERO_HIGH_TICKS - 1);
  localparam logic [CW-1:0] ONE_LAST   = CW'(ONE_HIGH_TICKS - 1);

  localparam logic [5:0] LAST_BIT = 6'd39;

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOST_LOW  = 3'd1,
    S_HOST_REL  = 3'd2,
    S_RESP_LOW  = 3'd3,
    S_RESP_HIGH = 3'd4,
    S_BIT_LOW   = 3'd5,
    S_BIT_HIGH  = 3'd6,
    S_END_LOW   = 3'd7
  } state_t;

  state_t state_q;
  state_t state_d;

  // ---------------------------------------------------------------------------
  // Registers and next-state signals
  // ---------------------------------------------------------------------------
  logic [1:0]    sync_q;
  logic          line_s;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [5:0]    bit_idx_q;
  logic [5:0]    bit_idx_d;
  logic [39:0]   frame_q;
  logic          accept;
  logic          drive_low;
  logic          drive_low_d;
  logic          busy_d;
  logic          frame_done_d;
  logic [7:0]    chk;
  logic          cur_bit;

  // Timed-phase helpers. These are set per state in the next-state logic.
  logic          timed;
  logic [CW-1:0] phase_last;
  state_t        phase_next;
  logic          phase_end;

  // ---------------------------------------------------------------------------
  // Open-drain drive
  // ---------------------------------------------------------------------------
  // Release is asynchronous with reset because drive_low clears on reset.
  assign dht11_io = drive_low ? 1'b0 : 1'bz;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  // The synchronizer resets to "line high" (idle bus). This avoids a false
  // start detection just after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], dht11_io};
    end
  end

  assign line_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // Tick prescaler
  // ---------------------------------------------------------------------------
  // The prescaler restarts on every state change. As a result, a phase of N
  // ticks always lasts exactly N*TICK_DIV cycles, measured from state entry.
  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else if ((state_d != state_q) || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Checksum and current data bit
  // ---------------------------------------------------------------------------
  // The 8-bit sum drops the carries, which gives the sum mod 256.
  assign chk     = (rh_int + rh_dec + temp_int + temp_dec) ^ {7'b0, corrupt_chk};
  assign cur_bit = frame_q[LAST_BIT - bit_idx_q];

  // ---------------------------------------------------------------------------
  // FSM process 1: state register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      // The frame is captured once, at acceptance. Later input changes are
      // invisible to the frame in flight.
      if (accept) begin
        frame_q <= {rh_int, rh_dec, temp_int, temp_dec, chk};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    accept     = 1'b0;
    timed      = 1'b0;
    phase_last = '0;
    phase_next = state_q;
    phase_end  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && !line_s) begin
          state_d = S_HOST_LOW;
          cnt_d   = '0;
        end
      end

      // Measure how long the host holds the line low. The count saturates at
      // the minimum, so very long start pulses cannot wrap the counter.
      S_HOST_LOW: begin
        if (line_s) begin
          cnt_d = '0;
          if (cnt_q >= MIN_START) begin
            state_d   = S_HOST_REL;
            accept    = 1'b1;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tick && (cnt_q != MIN_START)) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // If the host pulls low again here, it is restarting the start pulse,
      // so measurement begins again from zero.
      S_HOST_REL: begin
        if (!line_s) begin
          state_d = S_HOST_LOW;
          cnt_d   = '0;
        end else begin
          timed      = 1'b1;
          phase_last = DELAY_LAST;
          phase_next = S_RESP_LOW;
        end
      end

      S_RESP_LOW: begin
        timed      = 1'b1;
        phase_last = RESP_LAST;
        phase_next = S_RESP_HIGH;
      end

      S_RESP_HIGH: begin
        timed      = 1'b1;
        phase_last = RESP_LAST;
        phase_next = S_BIT_LOW;
      end

      S_BIT_LOW: begin
        timed      = 1'b1;
        phase_last = BITL_LAST;
        phase_next = S_BIT_HIGH;
      end

      // The high time encodes the bit value.
      S_BIT_HIGH: begin
        timed      = 1'b1;
        phase_last = cur_bit ? ONE_LAST : ZERO_LAST;
        phase_next = (bit_idx_q == LAST_BIT) ? S_END_LOW : S_BIT_LOW;
      end

      S_END_LOW: begin
        timed      = 1'b1;
        phase_last = BITL_LAST;
        phase_next = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared countdown for every fixed-length phase.
    if (timed && tick) begin
      if (cnt_q == phase_last) begin
        phase_end = 1'b1;
        state_d   = phase_next;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    if (phase_end && (state_q == S_BIT_HIGH)) begin
      bit_idx_d = bit_idx_q + 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: output logic
  // ---------------------------------------------------------------------------
  // Outputs are decoded from the next state and then registered. This keeps
  // them glitch-free and aligned cycle-for-cycle with state_q.
  always_comb begin
    drive_low_d  = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;

    case (state_d)
      S_RESP_LOW, S_BIT_LOW, S_END_LOW: drive_low_d = 1'b1;
      default:                          drive_low_d = 1'b0;
    endcase

    busy_d       = (state_d != S_IDLE) && (state_d != S_HOST_LOW);
    frame_done_d = (state_q == S_END_LOW) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drive_low  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      drive_low  <= drive_low_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
